// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: phase encodings and the
// address-width helper used to size the image memory port.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_INPUT  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_OUTPUT = 2'b11
  } state_t;

  // Ceiling log2 for elaboration-time sizing; bounded loop keeps it synthesizable.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_watchdog.sv
// Cycle watchdog: counts enabled cycles from a clear and raises a terminal
// flag once WDT_LIMIT cycles have been counted (flag is high in the
// WDT_LIMIT-th enabled cycle). Reusable for any cycle-time monitor.
module scan_watchdog
#(
  parameter int WDT_W     = 16,
  parameter int WDT_LIMIT = 1000
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam logic [WDT_W-1:0] LAST = WDT_W'(WDT_LIMIT - 1);

  logic [WDT_W-1:0] count;

  assign terminal = (count == LAST);

  // Counter: clear dominates, saturates at the terminal value.
  always_ff @(posedge clk) begin
    if (clr || clear) begin
      count <= '0;
    end else if (en && !terminal) begin
      count <= count + WDT_W'(1);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// PLC scan-cycle sequencer: snapshots the input pins into the input image,
// runs the enabled execution units until all report done (under a
// watchdog), then reads the output image back and updates the pins
// atomically. Owns image memory port 1 during the I/O phases.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int  N_IO      = 16,
  parameter int  N_CPU     = 2,
  parameter int  WDT_W     = 16,
  parameter int  WDT_LIMIT = 1000,
  parameter int  CNT_W     = 16,
  localparam int IMG_AW    = clog2(N_IO) + 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              RUN,
  input  logic [N_CPU-1:0]  CPU_EN,
  input  logic [N_IO-1:0]   IN_PINS,
  output logic [N_IO-1:0]   OUT_PINS,
  output logic [IMG_AW-1:0] IMG_A,
  output logic              IMG_DI,
  output logic              IMG_WE,
  input  logic              IMG_DQ,
  output logic [N_CPU-1:0]  START,
  input  logic [N_CPU-1:0]  DONE,
  output logic [1:0]        STATE,
  output logic              WDT_ERR,
  output logic [CNT_W-1:0]  SCAN_CNT
);

  // idx is one bit wider than the image half so OUTPUT can count to N_IO
  // for its extra drain cycle.
  localparam int IDX_LOG = IMG_AW - 1;
  localparam int IDX_W   = IMG_AW;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IO - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_IO);

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [IDX_LOG-1:0] idx_lo;
  logic [N_IO-1:0]    snap;
  logic [N_IO-1:0]    shadow;
  logic [N_IO-1:0]    out_nx;
  logic [N_CPU-1:0]   en_q;
  logic [N_CPU-1:0]   done_q;
  logic               all_done;
  logic               wdt_term;
  logic               in_last;
  logic               out_last;
  logic               wdt_fault;
  logic               scan_go;

  // Read-capture stage: address issued in one cycle, data lands the next.
  logic [IDX_LOG-1:0] rd_idx_p1;
  logic               vld_p1;

  assign idx_lo    = idx[IDX_LOG-1:0];
  assign all_done  = &done_q;
  assign in_last   = (state == ST_INPUT)  && (idx == IDX_LAST);
  assign out_last  = (state == ST_OUTPUT) && (idx == IDX_END);
  assign wdt_fault = (state == ST_EXEC) && !all_done && wdt_term;
  assign scan_go   = (state_nx == ST_INPUT) && (state != ST_INPUT);
  assign STATE     = state;

  scan_watchdog #(
    .WDT_W     (WDT_W),
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk      (CLK),
    .clr      (CLR),
    .clear    (state != ST_EXEC),
    .en       (state == ST_EXEC),
    .terminal (wdt_term)
  );

  // Next-state and memory/CPU handshake outputs, all from registered state.
  always_comb begin
    state_nx = state;
    IMG_A    = '0;
    IMG_DI   = 1'b0;
    IMG_WE   = 1'b0;
    START    = '0;
    case (state)
      ST_IDLE: begin
        if (RUN && !WDT_ERR) state_nx = ST_INPUT;
      end
      ST_INPUT: begin
        IMG_A  = {1'b0, idx_lo};
        IMG_DI = snap[idx_lo];
        IMG_WE = 1'b1;
        if (idx == IDX_LAST) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        START = en_q;
        if (all_done)      state_nx = ST_OUTPUT;
        else if (wdt_term) state_nx = ST_IDLE;
      end
      ST_OUTPUT: begin
        IMG_A = {1'b1, idx_lo};
        if (idx == IDX_END) state_nx = RUN ? ST_INPUT : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Phase register.
  always_ff @(posedge CLK) begin
    if (CLR) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Address index: walks each I/O phase, parked at zero otherwise.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      idx <= '0;
    end else begin
      case (state)
        ST_INPUT:  idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        ST_OUTPUT: idx <= (idx == IDX_END)  ? '0 : idx + IDX_W'(1);
        default:   idx <= '0;
      endcase
    end
  end

  // Input snapshot taken on the cycle a scan starts; later pin changes are ignored.
  always_ff @(posedge CLK) begin
    if (scan_go) snap <= IN_PINS;
  end

  // CPU enable/done tracking; disabled units are pre-marked done on entry.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      en_q   <= '0;
      done_q <= '0;
    end else if (in_last) begin
      en_q   <= CPU_EN;
      done_q <= ~CPU_EN;
    end else if (state == ST_EXEC) begin
      done_q <= done_q | (DONE & en_q);
    end
  end

  // Sticky fault, pin update and scan count; all cleared only by CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      WDT_ERR  <= 1'b0;
      OUT_PINS <= '0;
      SCAN_CNT <= '0;
    end else begin
      if (wdt_fault) WDT_ERR <= 1'b1;
      if (out_last) begin
        OUT_PINS <= out_nx;
        SCAN_CNT <= SCAN_CNT + CNT_W'(1);
      end
    end
  end

  // ---- stage p1: read data capture ----
  // Capture valid tracks the issued read addresses.
  always_ff @(posedge CLK) begin
    if (CLR) vld_p1 <= 1'b0;
    else     vld_p1 <= (state == ST_OUTPUT) && (idx != IDX_END);
  end

  // Capture index kept separate from idx so issue and capture never alias.
  always_ff @(posedge CLK) begin
    rd_idx_p1 <= idx_lo;
  end

  // Shadow image filled bit by bit; pins only see it as a whole.
  always_ff @(posedge CLK) begin
    if (vld_p1) shadow[rd_idx_p1] <= IMG_DQ;
  end

  // Final image merges the last bit still arriving in the drain cycle.
  always_comb begin
    out_nx            = shadow;
    out_nx[rd_idx_p1] = IMG_DQ;
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: the stimulus process plans each scan as a
// timeline (fixed-length I/O phases, EXEC length from the latest DONE or
// the watchdog limit) and publishes the expected outputs per cycle; one
// compare process checks them on the falling edge.
module tb_scan_sequencer;
  import scan_pkg::*;

  localparam int N_IO      = 16;
  localparam int N_CPU     = 2;
  localparam int WDT_W     = 16;
  localparam int WDT_LIMIT = 20;
  localparam int CNT_W     = 16;
  localparam int IMG_AW    = 5;

  logic              CLK = 1'b0;
  logic              CLR;
  logic              RUN;
  logic [N_CPU-1:0]  CPU_EN;
  logic [N_IO-1:0]   IN_PINS;
  logic [N_IO-1:0]   OUT_PINS;
  logic [IMG_AW-1:0] IMG_A;
  logic              IMG_DI;
  logic              IMG_WE;
  logic              IMG_DQ;
  logic [N_CPU-1:0]  START;
  logic [N_CPU-1:0]  DONE;
  logic [1:0]        STATE;
  logic              WDT_ERR;
  logic [CNT_W-1:0]  SCAN_CNT;

  always #5 CLK = ~CLK;

  scan_sequencer #(
    .N_IO(N_IO), .N_CPU(N_CPU), .WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .CLR(CLR), .RUN(RUN), .CPU_EN(CPU_EN), .IN_PINS(IN_PINS),
    .OUT_PINS(OUT_PINS), .IMG_A(IMG_A), .IMG_DI(IMG_DI), .IMG_WE(IMG_WE),
    .IMG_DQ(IMG_DQ), .START(START), .DONE(DONE), .STATE(STATE),
    .WDT_ERR(WDT_ERR), .SCAN_CNT(SCAN_CNT)
  );

  // Image memory: input half written by the DUT, output half by the bench
  // acting as the CPUs; one-cycle read latency.
  logic in_img  [N_IO];
  logic out_img [N_IO];
  always @(posedge CLK) begin
    if (IMG_WE && !IMG_A[4]) in_img[IMG_A[3:0]] <= IMG_DI;
    IMG_DQ <= IMG_A[4] ? out_img[IMG_A[3:0]] : in_img[IMG_A[3:0]];
  end

  int n_checks = 0;
  int n_errors = 0;
  int exec_cnt = 0;
  int we_cnt   = 0;

  // Expected outputs for the current cycle.
  bit                e_vld = 1'b0;
  state_t            e_state = ST_IDLE;
  logic              e_we = 1'b0;
  logic [IMG_AW-1:0] e_a = '0;
  bit                e_chk_a = 1'b0;
  logic              e_di = 1'b0;
  logic [N_CPU-1:0]  e_start = '0;

  // Model state persisting across scans.
  logic [N_IO-1:0]   m_out = '0;
  logic [CNT_W-1:0]  m_cnt = '0;
  logic              m_err = 1'b0;
  state_t            m_dec = ST_IDLE;
  bit                pend_upd = 1'b0;
  bit                pend_err = 1'b0;
  bit                pend_rst = 1'b0;
  logic [N_IO-1:0]   pend_out = '0;

  int               scans_done = 0;
  logic [N_IO-1:0]  last_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the published expectation.
  always @(negedge CLK) begin
    if (e_vld) begin
      check("STATE",    32'(STATE),    32'(e_state));
      check("IMG_WE",   32'(IMG_WE),   32'(e_we));
      if (e_chk_a) check("IMG_A", 32'(IMG_A), 32'(e_a));
      if (e_we)    check("IMG_DI", 32'(IMG_DI), 32'(e_di));
      check("START",    32'(START),    32'(e_start));
      check("OUT_PINS", 32'(OUT_PINS), 32'(m_out));
      check("WDT_ERR",  32'(WDT_ERR),  32'(m_err));
      check("SCAN_CNT", 32'(SCAN_CNT), 32'(m_cnt));
      if (STATE == 2'b10) exec_cnt++;
      if (IMG_WE) we_cnt++;
    end
  end

  // One clock: publish expectation, advance, then apply model effects of that edge.
  task automatic cyc(input state_t st, input logic we, input logic [IMG_AW-1:0] a,
                     input bit ca, input logic di, input logic [N_CPU-1:0] stv);
    e_state = st; e_we = we; e_a = a; e_chk_a = ca; e_di = di; e_start = stv;
    e_vld = 1'b1;
    @(posedge CLK); #1;
    if (pend_rst) begin
      m_out = '0; m_cnt = '0; m_err = 1'b0; m_dec = ST_IDLE;
      pend_rst = 1'b0; pend_upd = 1'b0; pend_err = 1'b0;
    end
    if (pend_upd) begin
      m_out = pend_out; m_cnt = m_cnt + CNT_W'(1); pend_upd = 1'b0;
    end
    if (pend_err) begin
      m_err = 1'b1; pend_err = 1'b0;
    end
  endtask

  task automatic do_reset();
    CLR = 1'b1; RUN = 1'b0; DONE = '0; CPU_EN = '0; IN_PINS = '0;
    e_vld = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    CLR = 1'b0;
    m_out = '0; m_cnt = '0; m_err = 1'b0; m_dec = ST_IDLE;
    pend_upd = 1'b0; pend_err = 1'b0; pend_rst = 1'b0;
    scans_done = 0; last_out = '0;
  endtask

  // Cycles between scans; run=1 only when a fault blocks new scans.
  task automatic idle(input int n, input logic run);
    for (int i = 0; i < n; i++) begin
      RUN = run; IN_PINS = 16'($urandom); CPU_EN = 2'($urandom); DONE = 2'($urandom);
      cyc(m_dec, 1'b0, '0, 1'b0, 1'b0, '0);
      m_dec = ST_IDLE;
    end
  endtask

  // One scan from its start decision to the cycle before the final OUTPUT
  // cycle (which becomes the next decision cycle). d0/d1 are the 1-based
  // EXEC cycles carrying each CPU's first DONE. abort_k>=0 asserts CLR in
  // that OUTPUT cycle. drop_run releases RUN early in EXEC.
  task automatic scan(input logic [N_IO-1:0] pins, input logic [N_CPU-1:0] en,
                      input int d0, input int d1, input logic [N_IO-1:0] oimg,
                      input int abort_k, input bit drop_run);
    int d [N_CPU];
    int mx;
    int len;
    bit fault;
    d[0] = d0; d[1] = d1;
    CLR = 1'b0; RUN = 1'b1; IN_PINS = pins; CPU_EN = 2'($urandom); DONE = 2'($urandom);
    cyc(m_dec, 1'b0, '0, 1'b0, 1'b0, '0);
    m_dec = ST_IDLE;
    for (int k = 0; k < N_IO; k++) begin
      RUN = drop_run ? 1'b1 : 1'($urandom);
      IN_PINS = 16'($urandom);
      CPU_EN = (k == N_IO - 1) ? en : 2'($urandom);
      DONE = 2'($urandom);
      cyc(ST_INPUT, 1'b1, {1'b0, 4'(k)}, 1'b1, pins[k], '0);
    end
    mx = 0;
    for (int i = 0; i < N_CPU; i++) if (en[i] && d[i] > mx) mx = d[i];
    len = mx + 1;
    fault = (len > WDT_LIMIT);
    if (fault) len = WDT_LIMIT;
    for (int j = 1; j <= len; j++) begin
      RUN = drop_run ? (j < 2) : 1'($urandom);
      for (int i = 0; i < N_CPU; i++) begin
        if (en[i]) DONE[i] = (j == d[i]) ? 1'b1 : ((j > d[i]) ? 1'($urandom) : 1'b0);
        else       DONE[i] = 1'($urandom);
      end
      if (j == 1) for (int i = 0; i < N_IO; i++) out_img[i] = oimg[i];
      if (fault && j == len) pend_err = 1'b1;
      cyc(ST_EXEC, 1'b0, '0, 1'b0, 1'b0, en);
    end
    if (fault) begin
      m_dec = ST_IDLE;
      return;
    end
    for (int k = 0; k < N_IO; k++) begin
      RUN = drop_run ? 1'b0 : 1'($urandom);
      DONE = 2'($urandom); IN_PINS = 16'($urandom); CPU_EN = 2'($urandom);
      if (k == abort_k) begin
        CLR = 1'b1; pend_rst = 1'b1;
        cyc(ST_OUTPUT, 1'b0, {1'b1, 4'(k)}, 1'b1, 1'b0, '0);
        CLR = 1'b0;
        return;
      end
      cyc(ST_OUTPUT, 1'b0, {1'b1, 4'(k)}, 1'b1, 1'b0, '0);
    end
    m_dec = ST_OUTPUT; pend_upd = 1'b1; pend_out = oimg;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_IO-1:0] v;
    logic [N_IO-1:0] o;
    logic [N_CPU-1:0] en;
    do_reset();
    check("rst_STATE",    32'(STATE),    32'h0);
    check("rst_OUT_PINS", 32'(OUT_PINS), 32'h0);
    check("rst_IMG_WE",   32'(IMG_WE),   32'h0);
    check("rst_IMG_A",    32'(IMG_A),    32'h0);
    check("rst_IMG_DI",   32'(IMG_DI),   32'h0);
    check("rst_START",    32'(START),    32'h0);
    check("rst_WDT_ERR",  32'(WDT_ERR),  32'h0);
    check("rst_SCAN_CNT", 32'(SCAN_CNT), 32'h0);

    // No CPUs enabled: one EXEC cycle, atomic pin update to the output image.
    exec_cnt = 0; we_cnt = 0;
    scan(16'hA5C3, 2'b00, 0, 0, 16'h1234, -1, 1'b0);
    scans_done++; last_out = 16'h1234;
    idle(1, 1'b0);
    check("noCPU_out",   32'(OUT_PINS), 32'h1234);
    check("noCPU_cnt",   32'(SCAN_CNT), 32'd1);
    check("noCPU_exec",  32'(exec_cnt), 32'd1);
    check("input_we",    32'(we_cnt),   32'd16);
    for (int i = 0; i < N_IO; i++) v[i] = in_img[i];
    check("input_image", 32'(v), 32'hA5C3);

    // Both CPUs, DONE at EXEC cycles 3 and 7: eight EXEC cycles.
    exec_cnt = 0;
    o = 16'($urandom);
    scan(16'hA5C3, 2'b11, 3, 7, o, -1, 1'b0);
    scans_done++; last_out = o;
    check("exec_3_7_len", 32'(exec_cnt), 32'd8);

    // Last DONE lands exactly at the watchdog limit: completes, no fault.
    exec_cnt = 0;
    o = 16'($urandom);
    scan(16'($urandom), 2'b11, 19, 5, o, -1, 1'b0);
    scans_done++; last_out = o;
    check("limit_len", 32'(exec_cnt), 32'd20);

    // Random scans with random gaps.
    for (int n = 0; n < 30; n++) begin
      en = 2'($urandom);
      o  = 16'($urandom);
      scan(16'($urandom), en, int'($urandom_range(19, 1)), int'($urandom_range(19, 1)),
           o, -1, 1'b0);
      scans_done++; last_out = o;
      if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(3, 1)), 1'b0);
    end
    idle(1, 1'b0);
    check("rand_cnt", 32'(SCAN_CNT), 32'(scans_done));

    // Watchdog: no DONE at all.
    exec_cnt = 0;
    scan(16'($urandom), 2'b11, 1000, 1000, 16'($urandom), -1, 1'b0);
    idle(10, 1'b1);
    check("wdt_len",   32'(exec_cnt), 32'd20);
    check("wdt_err",   32'(WDT_ERR),  32'd1);
    check("wdt_state", 32'(STATE),    32'h0);
    check("wdt_start", 32'(START),    32'h0);
    check("wdt_out",   32'(OUT_PINS), 32'(last_out));
    check("wdt_cnt",   32'(SCAN_CNT), 32'(scans_done));

    // CLR in the middle of OUTPUT: everything back to reset values.
    do_reset();
    scan(16'($urandom), 2'b11, 2, 4, 16'hFFFF, 5, 1'b0);
    idle(2, 1'b0);
    check("clr_out",   32'(OUT_PINS), 32'h0);
    check("clr_state", 32'(STATE),    32'h0);
    check("clr_cnt",   32'(SCAN_CNT), 32'h0);

    // RUN dropped during EXEC: scan completes once, then stays idle.
    do_reset();
    scan(16'($urandom), 2'b11, 3, 5, 16'hBEEF, -1, 1'b1);
    idle(6, 1'b0);
    check("drop_cnt",   32'(SCAN_CNT), 32'd1);
    check("drop_state", 32'(STATE),    32'h0);
    check("drop_out",   32'(OUT_PINS), 32'hBEEF);

    e_vld = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
